// File: rtl/counter_nbit_rev.sv
// rtl/counter_nbit_rev.sv - up/down counter with load, limit, wrap/oneshot modes and IDLE/RUN/DONE control
// Optional macro CNT_RC_REG_EN registers Rc (pulse follows the terminal edge instead of preceding it).
module counter_nbit_rev #(
  parameter int                WIDTH   = 32,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s,
  input  logic             Load,
  input  logic [WIDTH-1:0] PData,
  input  logic [WIDTH-1:0] Limit,
  input  logic             oneshot,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt_q;
  logic             at_terminal;
  logic             term_hit;

  // Up-count treats anything at or above Limit as terminal, so a load above Limit never runs past all-ones.
  assign at_terminal = s ? (cnt_q == '0) : (cnt_q >= Limit);
  assign term_hit    = (state == ST_RUN) && en && !Load && at_terminal;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
      state <= ST_IDLE;
    end else if (Load) begin
      cnt_q <= PData;
      state <= ST_RUN;
    end else if ((state == ST_RUN) && en) begin
      if (at_terminal) begin
        if (oneshot) begin
          state <= ST_DONE;
        end else begin
          cnt_q <= s ? Limit : '0;
        end
      end else begin
        cnt_q <= s ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
      end
    end
  end

`ifdef CNT_RC_REG_EN
  logic rc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q <= 1'b0;
    end else begin
      rc_q <= term_hit;
    end
  end

  assign Rc = rc_q;
`else
  // A cycle that resets is never a terminal event.
  assign Rc = term_hit && !rst;
`endif

  assign cnt  = cnt_q;
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
